ta_ldd_resp: RTL and testbench



---
 rtl/ta_ldd_pkg.sv | 16 +
 rtl/ta_sync_ff.sv | 21 ++
 rtl/ta_ldd_resp.sv | 135 +++++++++++++
 tb/tb_ta_ldd_resp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ta_ldd_pkg.sv
// Shared types and default sizing for the laser-diode-driver handshake responder.
package ta_ldd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StHold,
    StAck
  } ldd_state_e;

  localparam int unsigned PwWDef     = 8;
  localparam int unsigned HoldWDef   = 16;
  localparam int unsigned CntWDef    = 16;
  localparam int unsigned WdogCycDef = 65535;

endpackage

// File: rtl/ta_sync_ff.sv
// Reset-clearable two-flop single-bit synchronizer for the clk250 domain.
module ta_sync_ff (
  input  logic clk250,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/ta_ldd_resp.sv
// LDD-side responder of the ldd_trig/lddr_rdy four-phase handshake: fire, hold off, acknowledge.
// Optional handshake watchdog is built when TA_LDD_WDOG_EN is defined.
module ta_ldd_resp
  import ta_ldd_pkg::*;
#(
  parameter int unsigned PW_W     = PwWDef,
  parameter int unsigned HOLD_W   = HoldWDef,
  parameter int unsigned CNT_W    = CntWDef,
  parameter int unsigned WDOG_CYC = WdogCycDef
) (
  input  logic              clk250,
  input  logic              rst,
  input  logic              ldd_trig,
  output logic              lddr_rdy,
  input  logic [PW_W-1:0]   pulse_width,
  input  logic [HOLD_W-1:0] holdoff,
  output logic              ldd_pulse,
  output logic              ldd_busy,
  output logic [CNT_W-1:0]  shot_cnt,
  output logic              wdog_err
);

  localparam int unsigned TmrW = (PW_W > HOLD_W) ? PW_W : HOLD_W;

  if (WDOG_CYC < 1) begin : g_bad_wdog
    $error("WDOG_CYC must be at least 1");
  end

  logic             trig_s;
  ldd_state_e       state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] shot_cnt_q, shot_cnt_d;
  logic             pulse_q, rdy_q, busy_q;
  logic             wdog_err_q;

  ta_sync_ff u_trig_sync (
    .clk250 (clk250),
    .rst    (rst),
    .d      (ldd_trig),
    .q      (trig_s)
  );

  // tmr counts down remaining cycles of the current phase; zero means last cycle.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    hold_d     = hold_q;
    shot_cnt_d = shot_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (trig_s) begin
          state_d    = StFire;
          tmr_d      = (pulse_width == '0) ? '0 : TmrW'(pulse_width) - TmrW'(1);
          hold_d     = holdoff;
          shot_cnt_d = shot_cnt_q + CNT_W'(1);
        end
      end
      StFire: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TmrW'(1);
        end else if (hold_q == '0) begin
          state_d = StAck;
        end else begin
          state_d = StHold;
          tmr_d   = TmrW'(hold_q) - TmrW'(1);
        end
      end
      StHold: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TmrW'(1);
        end else begin
          state_d = StAck;
        end
      end
      StAck: begin
        // A tripped watchdog pins the FSM here until reset.
        if (!trig_s && !wdog_err_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      hold_q     <= '0;
      shot_cnt_q <= '0;
      pulse_q    <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      hold_q     <= hold_d;
      shot_cnt_q <= shot_cnt_d;
      pulse_q    <= (state_d == StFire);
      rdy_q      <= (state_d == StAck);
      busy_q     <= (state_d != StIdle);
    end
  end

`ifdef TA_LDD_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYC + 1);

  logic [WdogW-1:0] wdog_cnt_q;

  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else if (state_q == StAck && trig_s && !wdog_err_q) begin
      if (wdog_cnt_q == WdogW'(WDOG_CYC - 1)) begin
        wdog_err_q <= 1'b1;
      end else begin
        wdog_cnt_q <= wdog_cnt_q + WdogW'(1);
      end
    end else begin
      wdog_cnt_q <= '0;
    end
  end
`else
  assign wdog_err_q = 1'b0;
`endif

  assign ldd_pulse = pulse_q;
  assign lddr_rdy  = rdy_q;
  assign ldd_busy  = busy_q;
  assign shot_cnt  = shot_cnt_q;
  assign wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_ta_ldd_resp.sv
// Randomized self-checking bench for ta_ldd_resp; each shot is predicted from its edge timeline.
module tb_ta_ldd_resp;

  localparam int unsigned PW_W     = 8;
  localparam int unsigned HOLD_W   = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned WDOG_CYC = 100;

  logic              clk250 = 1'b0;
  logic              rst = 1'b1;
  logic              ldd_trig = 1'b0;
  logic [PW_W-1:0]   pulse_width = '0;
  logic [HOLD_W-1:0] holdoff = '0;
  logic              lddr_rdy, ldd_pulse, ldd_busy, wdog_err;
  logic [CNT_W-1:0]  shot_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt = 0;

  ta_ldd_resp #(
    .PW_W     (PW_W),
    .HOLD_W   (HOLD_W),
    .CNT_W    (CNT_W),
    .WDOG_CYC (WDOG_CYC)
  ) dut (
    .clk250      (clk250),
    .rst         (rst),
    .ldd_trig    (ldd_trig),
    .lddr_rdy    (lddr_rdy),
    .pulse_width (pulse_width),
    .holdoff     (holdoff),
    .ldd_pulse   (ldd_pulse),
    .ldd_busy    (ldd_busy),
    .shot_cnt    (shot_cnt),
    .wdog_err    (wdog_err)
  );

  always #5 clk250 = ~clk250;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk250);
    #1;
  endtask

  // One shot: trigger seen at edge 0, sampled low at edge t_drop (>=1).
  // Parameters optionally scrambled mid-shot; the shot must use the values present at edge 2.
  task automatic run_shot(input int w, input int h, input int t_drop, input bit scramble);
    int wl, ack_start, exit_e, prev, nxt;
    logic [CNT_W+3:0] got, exp;
    wl        = (w == 0) ? 1 : w;
    ack_start = 2 + wl + h;
    exit_e    = (t_drop + 2 > ack_start + 1) ? t_drop + 2 : ack_start + 1;
    prev      = model_cnt;
    nxt       = (model_cnt + 1) % (1 << CNT_W);
    pulse_width = PW_W'(w);
    holdoff     = HOLD_W'(h);
    ldd_trig    = 1'b1;
    for (int k = 0; k <= exit_e + 1; k++) begin
      step();
      exp = {1'(k >= 2 && k < 2 + wl), 1'(k >= ack_start && k < exit_e),
             1'(k >= 2 && k < exit_e), 1'b0, CNT_W'((k >= 2) ? nxt : prev)};
      got = {ldd_pulse, lddr_rdy, ldd_busy, wdog_err, shot_cnt};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL shot(w=%0d h=%0d t=%0d) edge %0d: pulse/rdy/busy/wdog/cnt got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                 w, h, t_drop, k, got[CNT_W+3], got[CNT_W+2], got[CNT_W+1], got[CNT_W],
                 got[CNT_W-1:0], exp[CNT_W+3], exp[CNT_W+2], exp[CNT_W+1], exp[CNT_W],
                 exp[CNT_W-1:0]);
      end
      if (scramble && k == 3) begin
        pulse_width = PW_W'($urandom);
        holdoff     = HOLD_W'($urandom_range(0, 40));
      end
      if (k == t_drop - 1) ldd_trig = 1'b0;
    end
    model_cnt = nxt;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ldd_trig = 1'b0;
    step();
    step();
    n_tests++;
    if ({ldd_pulse, lddr_rdy, ldd_busy, wdog_err, shot_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got p=%b r=%b b=%b w=%b c=%0d want all 0",
               ldd_pulse, lddr_rdy, ldd_busy, wdog_err, shot_cnt);
    end
    rst = 1'b0;
    model_cnt = 0;
    step();
  endtask

  task automatic test_directed();
    run_shot(4, 10, 30, 1'b0);
    run_shot(0, 0, 10, 1'b0);
    run_shot(3, 2, 1, 1'b0);
    run_shot(1, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int w, h, t;
      w = $urandom_range(0, 20);
      h = $urandom_range(0, 20);
      t = $urandom_range(1, 2 + ((w == 0) ? 1 : w) + h + 20);
      run_shot(w, h, t, 1'b1);
    end
  endtask

  task automatic test_reset_mid_fire();
    pulse_width = 8'd8;
    holdoff     = 16'd5;
    ldd_trig    = 1'b1;
    for (int k = 0; k <= 3; k++) step();
    n_tests++;
    if (ldd_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_fire_pulse: got %b want 1", ldd_pulse);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({ldd_pulse, lddr_rdy, ldd_busy, wdog_err, shot_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got p=%b r=%b b=%b w=%b c=%0d want all 0",
               ldd_pulse, lddr_rdy, ldd_busy, wdog_err, shot_cnt);
    end
    ldd_trig = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_cnt = 0;
    step();
    run_shot(3, 2, 20, 1'b0);
  endtask

  task automatic test_back_to_back();
    int start;
    start = model_cnt;
    for (int i = 0; i < 260; i++) begin
      int w, h;
      w = $urandom_range(0, 3);
      h = $urandom_range(0, 3);
      run_shot(w, h, $urandom_range(1, 2 + ((w == 0) ? 1 : w) + h + 3), 1'b0);
      if (model_cnt == 0) begin
        n_tests++;
        if (shot_cnt !== '0) begin
          n_fail++;
          $display("FAIL cnt_wrap: got %0d want 0", shot_cnt);
        end
      end
    end
    n_tests++;
    if (int'(shot_cnt) != (start + 260) % (1 << CNT_W)) begin
      n_fail++;
      $display("FAIL cnt_after_burst: got %0d want %0d", shot_cnt, (start + 260) % (1 << CNT_W));
    end
  endtask

  task automatic test_wdog();
`ifdef TA_LDD_WDOG_EN
    pulse_width = 8'd1;
    holdoff     = 16'd0;
    ldd_trig    = 1'b1;
    // ACK entered after edge 3; error expected after edge 3 + WDOG_CYC.
    for (int k = 0; k <= 3 + WDOG_CYC + 2; k++) begin
      step();
      if (k >= 3 + WDOG_CYC - 2) begin
        n_tests++;
        if (wdog_err !== 1'(k >= 3 + WDOG_CYC)) begin
          n_fail++;
          $display("FAIL wdog_rise edge %0d: got %b want %b", k, wdog_err, k >= 3 + WDOG_CYC);
        end
      end
    end
    ldd_trig = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_tests++;
    if ({wdog_err, lddr_rdy, ldd_busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL wdog_sticky: got err/rdy/busy %b%b%b want 111", wdog_err, lddr_rdy, ldd_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({wdog_err, lddr_rdy, ldd_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL wdog_clear: got err/rdy/busy %b%b%b want 000", wdog_err, lddr_rdy, ldd_busy);
    end
    step();
    rst = 1'b0;
    model_cnt = 0;
    step();
    run_shot(2, 3, 12, 1'b0);
`else
    // Trigger held far beyond WDOG_CYC; wdog_err must stay 0 on every sampled edge.
    run_shot(2, 3, 3 * WDOG_CYC, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_fire();
    test_back_to_back();
    test_wdog();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete, want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
